and_array_bist: RTL and testbench
=================================

// Module: and_array_bist
// PURPOSE
//  Parametrised N-channel, K-input AND gate array (generalised 74LS08/11/21 family) with registered outputs
//  and an on-chip self-test sequencer. In functional mode it is a drop-in registered AND array. In test mode it
//  applies all 2^K input patterns to every channel, checks each result and reports pass/fail per channel.
//  Sits between board-level stimulus/switch logic and LED/status outputs in the session lab designs.
// PARAMETERS
//  CH     3    number of AND channels (>=1)
//  K      3    inputs per channel (2..8)
//  ERR_W  K+1  width of error counter (derived: counts up to 2^K)
// PORTS
//  in_clk       in   1       rising-edge clock
//  in_rst_n     in   1       asynchronous active-low reset
//  in_mode      in   1       0 = functional, 1 = self-test
//  in_start     in   1       1-cycle pulse; starts self-test (in_mode=1 only)
//  in_data      in   CH*K    functional inputs; channel c = in_data[c*K +: K]
//  in_fault     in   CH      fault injection: channel c output forced stuck-at-0 when bit set (both modes)
//  out_y        out  CH      registered AND outputs
//  out_vec      out  K       pattern currently applied in test mode (0 in functional mode)
//  out_busy     out  1       self-test running
//  out_done     out  1       self-test completed, results valid
//  out_pass     out  1       1 when done and err_cnt==0
//  out_err_cnt  out  ERR_W   number of failing patterns
//  out_fail_ch  out  CH      sticky OR of channels that mismatched
// BEHAVIOUR
//  - Reset (async, in_rst_n=0): all outputs 0 immediately; FSM -> IDLE; vector counter 0.
//  - Functional (in_mode=0): out_y[c] <= &in_data[c*K +: K] & ~in_fault[c]; latency 1 cycle.
//  - FSM states: IDLE, APPLY, CHECK, DONE.
//    IDLE : in_mode=1 & in_start -> APPLY; clears err_cnt, fail_ch, done, pass; vec=0; busy=1.
//    APPLY: array inputs = {CH{vec}}; out_y registers at end of cycle -> CHECK.
//    CHECK: expected e = &vec; mismatch mask m[c] = out_y[c] ^ e. If |m: err_cnt+1, fail_ch |= m.
//           vec==2^K-1 -> DONE, else vec+1 -> APPLY. 2 cycles/pattern; busy for exactly 2*2^K cycles.
//    DONE : busy=0, done=1, pass=(err_cnt==0); results held. in_start -> APPLY (rerun, clears first);
//           in_mode=0 -> IDLE (done, pass cleared; err_cnt/fail_ch held until next start).
//  - in_start while busy: ignored. in_start with in_mode=0: ignored.
//  - in_mode 1->0 while busy: abort to IDLE next edge; busy=0, done=0, pass=0; out_y returns to functional.
//  - err_cnt cannot overflow (max 2^K fits ERR_W); no wrap logic. vec wraps only via DONE transition.
//  - in_fault changing mid-test: takes effect from the next APPLY; no restart.
//  - Test mode ignores in_data; out_y shows test results so observers see the array respond.
// STRUCTURE
//  - Package and_bist_pkg: state enum (IDLE/APPLY/CHECK/DONE, 2-bit), expected-value function
//    and_expect(vec).
//  - Sub-module and_gate_array #(CH,K): CH*K input bus, in_fault mask, registered CH outputs,
//    async active-low reset. Top = input mux (functional vs {CH{vec}}) + FSM + checker.
// TESTING (CH=3, K=3 unless noted)
//  1 Functional: in_data=9'b111_011_111, in_fault=0 -> out_y=3'b101 one cycle later; in_fault=3'b001 ->
//    out_y=3'b100.
//  2 Clean self-test: in_mode=1, start pulse -> busy high 16 cycles, out_vec 0..7, then done=1, pass=1,
//    err_cnt=0, fail_ch=0.
//  3 Fault: in_fault=3'b010, run test -> only vec=3'b111 fails: err_cnt=1, fail_ch=3'b010, pass=0.
//  4 Async reset at cycle 5 of test -> all outputs 0 without clock edge; start after release gives full
//    16-cycle run.
//  5 Abort/ignore: start pulse at busy cycle 3 ignored (count still 16); in_mode->0 at cycle 7 -> IDLE,
//    done=0, out_y functional next cycle.
//  6 Param sweep: CH=1,K=2 and CH=8,K=8 clean runs -> busy 8 and 512 cycles, pass=1; CH=8,K=8 with
//    in_fault=8'hFF -> err_cnt=1, fail_ch=8'hFF.

Source files
------------

// File: rtl/and_bist_pkg.sv
// Shared types and helpers for the self-testing AND gate array.
package and_bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int MAX_K = 8;

   // Golden AND of the low k bits of a test vector.
   function automatic logic and_expect(input logic [MAX_K-1:0] vec, input int k);
      logic r;
      r = 1'b1;
      for (int i = 0; i < MAX_K; i++) begin
         if (i < k) r = r & vec[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/and_gate_array.sv
// CH independent K-input AND gates with registered outputs and stuck-at-0 fault injection.
module and_gate_array #(
   parameter int CH = 3,
   parameter int K  = 3
) (
   input  logic            in_clk,
   input  logic            in_rst_n,
   input  logic [CH*K-1:0] in_data,
   input  logic [CH-1:0]   in_fault,
   output logic [CH-1:0]   out_y
);

   logic [CH-1:0] r_y;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_y <= '0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            r_y[c] <= (&in_data[c*K +: K]) & ~in_fault[c];
         end
      end
   end

   assign out_y = r_y;

endmodule

// File: rtl/and_array_bist.sv
// Registered AND array with a built-in sequencer that sweeps all 2^K patterns and reports per-channel failures.
module and_array_bist
   import and_bist_pkg::*;
#(
   parameter int CH    = 3,
   parameter int K     = 3,
   parameter int ERR_W = K + 1
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             in_mode,
   input  logic             in_start,
   input  logic [CH*K-1:0]  in_data,
   input  logic [CH-1:0]    in_fault,
   output logic [CH-1:0]    out_y,
   output logic [K-1:0]     out_vec,
   output logic             out_busy,
   output logic             out_done,
   output logic             out_pass,
   output logic [ERR_W-1:0] out_err_cnt,
   output logic [CH-1:0]    out_fail_ch
);

   state_t           r_state;
   logic [K-1:0]     r_vec;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [ERR_W-1:0] r_err_cnt;
   logic [CH-1:0]    r_fail_ch;

   logic [CH*K-1:0]  w_arr_in;
   logic [CH-1:0]    w_y;
   logic [CH-1:0]    w_mis;
   logic [MAX_K-1:0] w_vec_ext;
   logic             w_exp;
   logic             w_last;

   // In test mode every channel sees the same sweep vector; in_data is ignored.
   assign w_arr_in  = in_mode ? {CH{r_vec}} : in_data;
   assign w_vec_ext = MAX_K'(r_vec);
   assign w_exp     = and_expect(w_vec_ext, K);
   assign w_mis     = w_y ^ {CH{w_exp}};
   assign w_last    = (r_vec == {K{1'b1}});

   and_gate_array #(
      .CH (CH),
      .K  (K)
   ) u_array (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .in_data  (w_arr_in),
      .in_fault (in_fault),
      .out_y    (w_y)
   );

   // Two cycles per pattern: APPLY registers the array, CHECK compares what it registered.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state   <= IDLE;
         r_vec     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_err_cnt <= '0;
         r_fail_ch <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_mode && in_start) begin
                  r_state   <= APPLY;
                  r_vec     <= '0;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_pass    <= 1'b0;
                  r_err_cnt <= '0;
                  r_fail_ch <= '0;
               end
            end
            APPLY: begin
               if (!in_mode) begin
                  r_state <= IDLE;
                  r_vec   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end else begin
                  r_state <= CHECK;
               end
            end
            CHECK: begin
               if (!in_mode) begin
                  r_state <= IDLE;
                  r_vec   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end else begin
                  if (|w_mis) begin
                     r_err_cnt <= r_err_cnt + ERR_W'(1);
                     r_fail_ch <= r_fail_ch | w_mis;
                  end
                  if (w_last) begin
                     r_state <= DONE;
                     r_vec   <= '0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     // Fold in the final pattern's verdict, which lands on this same edge.
                     r_pass  <= (r_err_cnt == '0) && !(|w_mis);
                  end else begin
                     r_state <= APPLY;
                     r_vec   <= r_vec + K'(1);
                  end
               end
            end
            DONE: begin
               if (!in_mode) begin
                  r_state <= IDLE;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end else if (in_start) begin
                  r_state   <= APPLY;
                  r_vec     <= '0;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_pass    <= 1'b0;
                  r_err_cnt <= '0;
                  r_fail_ch <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign out_y       = w_y;
   assign out_vec     = r_vec;
   assign out_busy    = r_busy;
   assign out_done    = r_done;
   assign out_pass    = r_pass;
   assign out_err_cnt = r_err_cnt;
   assign out_fail_ch = r_fail_ch;

endmodule

// File: tb/tb_and_array_bist.sv
// Scoreboard bench for and_array_bist: expected results are queued by stimulus and popped by monitors.
module tb_and_array_bist;

   logic clk = 1'b0;
   logic rstN;
   always #5 clk = ~clk;

   logic       mode, start;
   logic [8:0] data;
   logic [2:0] fault, y, vec, failCh;
   logic       busy, done, pass;
   logic [3:0] errCnt;

   logic       mode12, start12, busy12, done12, pass12;
   logic [1:0] data12, vec12;
   logic [0:0] fault12, y12, fail12;
   logic [2:0] err12;

   logic        mode88, start88, busy88, done88, pass88;
   logic [63:0] data88;
   logic [7:0]  fault88, y88, vec88, fail88;
   logic [8:0]  err88;

   and_array_bist #(.CH(3), .K(3)) dut (
      .in_clk(clk), .in_rst_n(rstN), .in_mode(mode), .in_start(start), .in_data(data),
      .in_fault(fault), .out_y(y), .out_vec(vec), .out_busy(busy), .out_done(done),
      .out_pass(pass), .out_err_cnt(errCnt), .out_fail_ch(failCh)
   );

   and_array_bist #(.CH(1), .K(2)) dut12 (
      .in_clk(clk), .in_rst_n(rstN), .in_mode(mode12), .in_start(start12), .in_data(data12),
      .in_fault(fault12), .out_y(y12), .out_vec(vec12), .out_busy(busy12), .out_done(done12),
      .out_pass(pass12), .out_err_cnt(err12), .out_fail_ch(fail12)
   );

   and_array_bist #(.CH(8), .K(8)) dut88 (
      .in_clk(clk), .in_rst_n(rstN), .in_mode(mode88), .in_start(start88), .in_data(data88),
      .in_fault(fault88), .out_y(y88), .out_vec(vec88), .out_busy(busy88), .out_done(done88),
      .out_pass(pass88), .out_err_cnt(err88), .out_fail_ch(fail88)
   );

   typedef struct {
      int         busyLen;
      int         errCnt;
      logic [7:0] failCh;
      logic       pass;
   } testExp_t;

   typedef struct {
      int         cyc;
      logic [2:0] y;
   } yExp_t;

   testExp_t q33[$];
   testExp_t q12[$];
   testExp_t q88[$];
   yExp_t    qY[$];

   int nCompared   = 0;
   int nMismatched = 0;
   int cyc         = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void missingExpect(input string name);
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: DUT reported done with no queued expectation", name);
   endfunction

   // Monitor for the 3x3 instance: busy length, vector sweep, end-of-test results, functional outputs.
   int       busyCnt = 0;
   logic     busyD   = 1'b0;
   logic     doneD   = 1'b0;
   testExp_t e33;
   yExp_t    ey;
   initial begin
      forever begin
         @(negedge clk);
         if (busy && !busyD) busyCnt = 1;
         else if (busy) busyCnt++;
         if (busy) checkOutput("out_vec", 32'(vec), 32'((busyCnt - 1) / 2));
         if (done && !doneD) begin
            if (q33.size() == 0) missingExpect("done33");
            else begin
               e33 = q33.pop_front();
               checkOutput("busy_len33", 32'(busyCnt), 32'(e33.busyLen));
               checkOutput("err_cnt33", 32'(errCnt), 32'(e33.errCnt));
               checkOutput("fail_ch33", 32'(failCh), 32'(e33.failCh[2:0]));
               checkOutput("pass33", 32'(pass), 32'(e33.pass));
            end
         end
         while (qY.size() > 0 && qY[0].cyc <= cyc) begin
            ey = qY.pop_front();
            if (ey.cyc < cyc) checkOutput("out_y_missed", 32'(ey.cyc), 32'(cyc));
            else checkOutput("out_y", 32'(y), 32'(ey.y));
         end
         busyD = busy;
         doneD = done;
      end
   end

   int       busyCnt12 = 0;
   logic     doneD12   = 1'b0;
   testExp_t e12;
   initial begin
      forever begin
         @(negedge clk);
         if (busy12) busyCnt12++;
         if (done12 && !doneD12) begin
            if (q12.size() == 0) missingExpect("done12");
            else begin
               e12 = q12.pop_front();
               checkOutput("busy_len12", 32'(busyCnt12), 32'(e12.busyLen));
               checkOutput("err_cnt12", 32'(err12), 32'(e12.errCnt));
               checkOutput("fail_ch12", 32'(fail12), 32'(e12.failCh[0]));
               checkOutput("pass12", 32'(pass12), 32'(e12.pass));
            end
            busyCnt12 = 0;
         end
         doneD12 = done12;
      end
   end

   int       busyCnt88 = 0;
   logic     doneD88   = 1'b0;
   testExp_t e88;
   initial begin
      forever begin
         @(negedge clk);
         if (busy88) busyCnt88++;
         if (done88 && !doneD88) begin
            if (q88.size() == 0) missingExpect("done88");
            else begin
               e88 = q88.pop_front();
               checkOutput("busy_len88", 32'(busyCnt88), 32'(e88.busyLen));
               checkOutput("err_cnt88", 32'(err88), 32'(e88.errCnt));
               checkOutput("fail_ch88", 32'(fail88), 32'(e88.failCh));
               checkOutput("pass88", 32'(pass88), 32'(e88.pass));
            end
            busyCnt88 = 0;
         end
         doneD88 = done88;
      end
   end

   task automatic applyStimulus(input logic [8:0] d, input logic [2:0] f, input logic [2:0] expY);
      @(negedge clk);
      data  = d;
      fault = f;
      qY.push_back('{cyc + 1, expY});
   endtask

   task automatic startTest33(input int bl, input int ec, input logic [7:0] fc, input logic p, input logic track);
      @(negedge clk);
      mode  = 1'b1;
      start = 1'b1;
      if (track) q33.push_back('{bl, ec, fc, p});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input int which, input int limit);
      int   n;
      logic d;
      n = 0;
      d = 1'b0;
      while (!d && n < limit) begin
         @(negedge clk);
         #1;
         n++;
         d = (which == 0) ? done : (which == 1) ? done12 : done88;
      end
      if (!d) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL wait_done%0d: done=0 after %0d cycles, expected 1", which, limit);
      end
   endtask

   task automatic waitBusyCnt(input int target);
      int n;
      n = 0;
      while (busyCnt < target && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (busyCnt < target) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL wait_busy: busy count %0d, expected %0d", busyCnt, target);
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN  = 1'b0;
      mode  = 1'b0; start = 1'b0; data = '0; fault = '0;
      mode12 = 1'b0; start12 = 1'b0; data12 = '0; fault12 = '0;
      mode88 = 1'b0; start88 = 1'b0; data88 = '0; fault88 = '0;
      #1;
      checkOutput("rst_y", 32'(y), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(errCnt), 32'd0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;

      $display("[TB] functional mode");
      applyStimulus(9'b111_011_111, 3'b000, 3'b101);
      applyStimulus(9'b111_011_111, 3'b001, 3'b100);
      applyStimulus(9'b111_111_111, 3'b000, 3'b111);
      applyStimulus(9'b110_101_011, 3'b000, 3'b000);
      applyStimulus(9'b111_111_111, 3'b110, 3'b001);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      checkOutput("start_in_func_busy", 32'(busy), 32'd0);

      $display("[TB] clean self-test");
      fault = 3'b000;
      startTest33(16, 0, 8'h00, 1'b1, 1'b1);
      waitDone(0, 40);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("done_held_pass", 32'(pass), 32'd1);
      checkOutput("done_vec", 32'(vec), 32'd0);

      $display("[TB] faulted self-test");
      fault = 3'b010;
      startTest33(16, 1, 8'h02, 1'b0, 1'b1);
      waitDone(0, 40);
      @(negedge clk);
      mode = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("exit_done", 32'(done), 32'd0);
      checkOutput("exit_pass", 32'(pass), 32'd0);
      checkOutput("exit_err_held", 32'(errCnt), 32'd1);
      checkOutput("exit_fail_held", 32'(failCh), 32'd2);
      fault = 3'b000;

      $display("[TB] start while busy ignored");
      startTest33(16, 0, 8'h00, 1'b1, 1'b1);
      waitBusyCnt(3);
      start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      waitDone(0, 40);

      $display("[TB] abort by mode change");
      @(negedge clk);
      mode = 1'b0;
      startTest33(0, 0, 8'h00, 1'b0, 1'b0);
      waitBusyCnt(7);
      mode  = 1'b0;
      data  = 9'b111_011_111;
      qY.push_back('{cyc + 1, 3'b101});
      @(negedge clk);
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_pass", 32'(pass), 32'd0);

      $display("[TB] async reset mid-test");
      fault = 3'b100;
      startTest33(0, 0, 8'h00, 1'b0, 1'b0);
      waitBusyCnt(5);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_vec", 32'(vec), 32'd0);
      checkOutput("arst_y", 32'(y), 32'd0);
      checkOutput("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      rstN  = 1'b1;
      fault = 3'b000;
      startTest33(16, 0, 8'h00, 1'b1, 1'b1);
      waitDone(0, 40);

      $display("[TB] parameter sweep");
      @(negedge clk);
      mode12 = 1'b1; start12 = 1'b1;
      q12.push_back('{8, 0, 8'h00, 1'b1});
      @(negedge clk);
      start12 = 1'b0;
      waitDone(1, 30);

      @(negedge clk);
      mode88 = 1'b1; start88 = 1'b1;
      q88.push_back('{512, 0, 8'h00, 1'b1});
      @(negedge clk);
      start88 = 1'b0;
      waitDone(2, 600);

      @(negedge clk);
      fault88 = 8'hFF; start88 = 1'b1;
      q88.push_back('{512, 1, 8'hFF, 1'b0});
      @(negedge clk);
      start88 = 1'b0;
      waitDone(2, 600);

      repeat (2) @(negedge clk);
      if (q33.size() != 0 || q12.size() != 0 || q88.size() != 0 || qY.size() != 0) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL leftover_expect: %0d/%0d/%0d/%0d pending, expected 0",
                  q33.size(), q12.size(), q88.size(), qY.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
